// File: rtl/hello_scroll_pkg.sv
// ============================================================================
// Module : hello_scroll_pkg
// Brief  : Shared types and character codes for the HELLO scroller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hello_scroll_pkg;

    typedef logic [1:0] char_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam char_t CH_H = 2'b00;
    localparam char_t CH_E = 2'b01;
    localparam char_t CH_L = 2'b10;
    localparam char_t CH_O = 2'b11;

endpackage

`default_nettype wire

// File: rtl/scroll_tick.sv
// ============================================================================
// Module : scroll_tick
// Brief  : Scroll-step prescaler; pulses tick at terminal count while enabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scroll_tick
    import hello_scroll_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // clr wins over en so a fresh start always begins a full period
    always_comb begin
        tick  = en && (cnt_q == TERM);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hello_scroller.sv
// ============================================================================
// Module : hello_scroller
// Brief  : Loads a short message and scrolls it leftward across 7-seg digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hello_scroller
    import hello_scroll_pkg::*;
#(
    parameter int NUM_DISP = 5,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wr_valid,
    input  logic [1:0]            wr_char,
    output logic                  wr_ready,
    output logic [2*NUM_DISP-1:0] disp_char,
    output logic [NUM_DISP-1:0]   disp_blank,
    output logic                  busy,
    output logic                  wrap
);

    localparam int            OW       = $clog2(MSG_LEN);
    localparam int            PW       = $clog2(MSG_LEN + 1);
    localparam logic [PW-1:0] PTR_FULL = PW'(MSG_LEN);
    localparam logic [OW-1:0] OFF_LAST = OW'(MSG_LEN - 1);
    localparam logic [OW:0]   LEN_EXT  = (OW + 1)'(MSG_LEN);

    state_t        state_q,  state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] offset_q, offset_d;
    logic          wrap_q,   wrap_d;
    char_t         msg_q [MSG_LEN];

    logic tick;
    logic tick_en;
    logic tick_clr;
    logic wr_en;
    logic buf_full;

    assign buf_full = (wr_ptr_q == PTR_FULL);
    assign wr_ready = (state_q == IDLE) && (wr_ptr_q < PTR_FULL);
    assign busy     = (state_q != IDLE);
    assign wrap     = wrap_q;
    assign wr_en    = wr_valid && wr_ready;
    // Prescaler freezes in the cycle stop is seen, so no step races the pause
    assign tick_en  = (state_q == SCROLL) && !stop;

    scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        offset_d = offset_q;
        wrap_d   = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (!stop && start && buf_full) begin
                    state_d  = SCROLL;
                    offset_d = '0;
                    tick_clr = 1'b1;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (tick) begin
                    if (offset_q == OFF_LAST) begin
                        offset_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                end else if (start) begin
                    state_d = SCROLL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            offset_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
        end
    end

    // Message storage carries no reset; it is only shown once fully loaded
    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg_q[wr_ptr_q[OW-1:0]] <= wr_char;
        end
    end

    // offset < MSG_LEN and distance < MSG_LEN, so one conditional subtract suffices
    for (genvar i = 0; i < NUM_DISP; i++) begin : g_disp
        localparam logic [OW:0] DIST = (OW + 1)'(NUM_DISP - 1 - i);
        logic [OW:0]   sum;
        logic [OW-1:0] idx;
        assign sum              = {1'b0, offset_q} + DIST;
        assign idx              = (sum >= LEN_EXT) ? OW'(sum - LEN_EXT) : sum[OW-1:0];
        assign disp_char[2*i+:2] = busy ? msg_q[idx] : 2'b00;
        assign disp_blank[i]    = ~busy;
    end

endmodule

`default_nettype wire

// File: tb/tb_hello_scroller.sv
// ============================================================================
// Module : tb_hello_scroller
// Brief  : Directed self-checking bench for hello_scroller (DIV=4, LEN=8, DISP=5).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hello_scroller;

    localparam int NUM_DISP = 5;
    localparam int MSG_LEN  = 8;
    localparam int TICK_DIV = 4;

    localparam logic [9:0] C_HELLO = 10'b00_01_10_10_11;
    localparam logic [9:0] C_ELLOO = 10'b01_10_10_11_11;
    localparam logic [9:0] C_ZERO  = 10'b0;
    localparam logic [4:0] B_ALL   = 5'b11111;
    localparam logic [4:0] B_NONE  = 5'b00000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       wr_valid;
    logic [1:0] wr_char;
    logic       wr_ready;
    logic [9:0] disp_char;
    logic [4:0] disp_blank;
    logic       busy;
    logic       wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hello_scroller #(
        .NUM_DISP (NUM_DISP),
        .MSG_LEN  (MSG_LEN),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .wr_valid   (wr_valid),
        .wr_char    (wr_char),
        .wr_ready   (wr_ready),
        .disp_char  (disp_char),
        .disp_blank (disp_blank),
        .busy       (busy),
        .wrap       (wrap)
    );

    typedef struct {
        logic       s;
        logic       p;
        logic       v;
        logic [1:0] c;
        logic [9:0] e_char;
        logic [4:0] e_blank;
        logic       e_busy;
        logic       e_ready;
        logic       e_wrap;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [9:0] e_char, input logic [4:0] e_blank,
                       input logic e_busy, input logic e_ready, input logic e_wrap);
        n_cmp++;
        if ({disp_char, disp_blank, busy, wr_ready, wrap} !== {e_char, e_blank, e_busy, e_ready, e_wrap}) begin
            n_fail++;
            $display("FAIL %s: got char=%b blank=%b busy=%b ready=%b wrap=%b, expected char=%b blank=%b busy=%b ready=%b wrap=%b",
                     name, disp_char, disp_blank, busy, wr_ready, wrap, e_char, e_blank, e_busy, e_ready, e_wrap);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic v, input logic [1:0] c);
        start    = s;
        stop     = p;
        wr_valid = v;
        wr_char  = c;
        @(posedge clk);
        #1;
    endtask

    // Expected display for message HELLOOOO at a given scroll offset
    function automatic logic [9:0] exp_disp(input int k);
        logic [1:0] m [8];
        logic [9:0] r;
        m = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        r = '0;
        for (int i = 0; i < 5; i++) r[2*i+:2] = m[(k + 4 - i) % 8];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, C_ZERO,  B_ALL,  1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, C_ZERO,  B_ALL,  1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, C_ZERO,  B_ALL,  1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 2'd0, C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'd0, C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 2'd0, C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 2'd0, C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 2'd0, C_ELLOO, B_NONE, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        wr_valid = 1'b0;
        wr_char  = 2'd0;
        @(posedge clk);
        #1;
        chk("reset_state", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Early start, load completion, ignored write, start and first step
        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].s, vt[i].p, vt[i].v, vt[i].c);
            chk($sformatf("load_vec%0d", i), vt[i].e_char, vt[i].e_blank,
                vt[i].e_busy, vt[i].e_ready, vt[i].e_wrap);
        end

        // Edge n after the start edge: offset = n/4, wrap only at n=32
        for (int n = 5; n <= 33; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            chk($sformatf("scroll_e%0d", n), exp_disp((n / 4) % 8), B_NONE, 1'b1, 1'b0, (n == 32));
        end

        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        chk("pre_pause", C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        chk("pause_enter", C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            chk($sformatf("hold_c%0d", n), C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        chk("resume", C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        chk("resume_p1", C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        chk("resume_step", C_ELLOO, B_NONE, 1'b1, 1'b0, 1'b0);

        // start+stop together must pause, not keep scrolling
        cyc(1'b1, 1'b1, 1'b0, 2'd0);
        chk("start_stop_hold", C_ELLOO, B_NONE, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            chk($sformatf("prio_hold_c%0d", n), C_ELLOO, B_NONE, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        chk("abort_idle", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        chk("start_after_abort", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);

        // Reload, scroll briefly, then reset between edges
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, (i < 1) ? 2'd0 : (i < 2) ? 2'd1 : (i < 4) ? 2'd2 : 2'd3);
        end
        chk("reload_full", C_ZERO, B_ALL, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        chk("restart", C_HELLO, B_NONE, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        chk("mid_scroll", exp_disp(1), B_NONE, 1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        chk("post_reset_idle", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 2'd3);
        chk("ptr_cleared_7", C_ZERO, B_ALL, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd3);
        chk("ptr_cleared_8", C_ZERO, B_ALL, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        chk("restart_all_o", 10'b11_11_11_11_11, B_NONE, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hello_scroller.md
HELLO_SCROLLER -- requirements
Module: hello_scroller

Interface
REQ-001 Parameter NUM_DISP, default 5: number of 7-segment character positions driven.
REQ-002 Parameter MSG_LEN, default 8: message buffer depth in characters; SHALL be >= NUM_DISP and >= 2.
REQ-003 Parameter TICK_DIV, default 25_000_000: clk cycles per scroll step; SHALL be >= 2.
REQ-004 clk  in  1: the single clock; all state is updated on the rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: level-sampled command to begin or resume scrolling.
REQ-007 stop  in  1: level-sampled command to pause scrolling, or to abort when already paused.
REQ-008 wr_valid  in  1: the character on wr_char is offered for loading.
REQ-009 wr_char  in  2: character code (H=00, E=01, L=10, O=11).
REQ-010 wr_ready  out  1: the block accepts wr_char in this cycle.
REQ-011 disp_char  out  2*NUM_DISP: character code for each position; bits [2i+1:2i] drive position i, where position 0 is the rightmost.
REQ-012 disp_blank  out  NUM_DISP: 1 means position i is blanked; the downstream blanks segments, ignoring disp_char.
REQ-013 busy  out  1: the state is SCROLL or HOLD.
REQ-014 wrap  out  1: one-cycle pulse when the scroll offset wraps from MSG_LEN-1 to 0.

Function
REQ-015 The FSM has exactly three states: IDLE, SCROLL and HOLD.
REQ-016 IDLE write handshake:
  - wr_ready = (state==IDLE) && (wr_ptr < MSG_LEN).
  - A write occurs when wr_valid && wr_ready; it stores buf[wr_ptr] = wr_char and increments wr_ptr.
  - wr_valid while not ready is ignored, and no data is lost from the buffer.
REQ-017 IDLE start:
  - If start=1 and wr_ptr==MSG_LEN (buffer full): go to SCROLL, with offset=0 and prescaler=0.
  - If start=1 with the buffer not full: start is ignored.
REQ-018 SCROLL stepping:
  - The prescaler counts 0..TICK_DIV-1.
  - At terminal count it returns to 0 and offset = (offset+1) mod MSG_LEN.
  - wrap is asserted in the same cycle that offset loads 0 from MSG_LEN-1.
REQ-019 SCROLL stop: stop=1 goes to HOLD; offset and prescaler freeze at their current values, and no step occurs in that cycle.
REQ-020 HOLD transitions:
  - stop=1: go to IDLE and clear wr_ptr to 0 (the buffer contents are retained but must be reloaded before the next start).
  - Else start=1: go to SCROLL and resume counting from the frozen prescaler value.
REQ-021 Simultaneous start and stop: stop takes priority in every state.
REQ-022 Display mapping, in SCROLL and HOLD:
  - Position i shows buf[(offset + NUM_DISP-1-i) mod MSG_LEN].
  - disp_blank = all zeros.
  - The message therefore moves one position leftward per step.
REQ-023 In IDLE, disp_blank = all ones and disp_char = all zeros.
REQ-024 disp_char, disp_blank, busy and wr_ready are combinational functions of registered state only, with no input-to-output paths; wrap is registered.
REQ-025 Modulo arithmetic SHALL be correct for non-power-of-two MSG_LEN; no index may exceed MSG_LEN-1.

Reset
REQ-026 Asserting reset, even mid-scroll or mid-load, immediately forces the following; it is asynchronous, with release synchronous to clk:
  - state=IDLE
  - wr_ptr=0, offset=0, prescaler=0
  - wrap=0, busy=0
  - disp_blank=all ones, disp_char=all zeros
  - wr_ready=1
REQ-027 Buffer contents need not be reset.

Structure
REQ-028 A shared package hello_scroll_pkg holds:
  - the state enum (IDLE, SCROLL, HOLD);
  - the character code constants CH_H, CH_E, CH_L, CH_O;
  - the char_t 2-bit typedef.
REQ-029 One sub-module, scroll_tick, implements the prescaler:
  - Ports: clk, reset, en, clr.
  - Output: tick, a one-cycle pulse at terminal count.
  - Its width is $clog2(TICK_DIV).

Verification (TICK_DIV=4, MSG_LEN=8, NUM_DISP=5)
REQ-030 Load and start: write H,E,L,L,O,O,O,O, then pulse start.
  - wr_ready drops after the 8th write.
  - busy=1.
  - Positions 4..0 show H,E,L,L,O.
  - After 4 cycles they show E,L,L,O,O.
REQ-031 Wrap: after 8 steps (32 cycles) from start, wrap pulses for exactly one cycle and the display returns to H,E,L,L,O.
REQ-032 Early start: start with only 3 characters written leaves the block in IDLE with busy=0, displays blanked, and wr_ready=1.
REQ-033 Pause and resume: stop 2 cycles after a step enters HOLD and the display is frozen for 20 cycles; start then resumes, and the next step occurs after 2 more cycles.
REQ-034 Priority and abort: start and stop together in SCROLL go to HOLD; a second stop goes to IDLE with all positions blanked and wr_ready=1.
REQ-035 Reset mid-scroll: asserting reset between clock edges makes outputs reset immediately; after release the block is IDLE and wr_ptr=0.
